gps_sample_capture: RTL
=======================

GPS_SAMPLE_CAPTURE -- requirements
Module: gps_sample_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: capture buffer size in 16-bit words; power of two, 16..4096.
REQ-002 SHALL have parameter AW, default 10: pointer width; equals log2(DEPTH).
REQ-003 SHALL have port clk  input  1: single clock, rising edge; all logic in this domain.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port din  input  1: registered 1-bit GPS sample, one sample per clk.
REQ-006 SHALL have port start  input  1: one-cycle pulse that begins a new capture.
REQ-007 SHALL have port rd  input  1: one-cycle pulse that pops one captured word.
REQ-008 SHALL have port dout  output  16: last popped word.
REQ-009 SHALL have port busy  output  1: high while the capture is filling.
REQ-010 SHALL have port done  output  1: high when the buffer is full and readable.
REQ-011 SHALL have port words  output  AW+1: count of words written in the current capture.
REQ-012 SHALL have port rd_err  output  1: sticky flag, set by rd while not in DONE.

Function
REQ-013 SHALL implement states IDLE, FILL and DONE; busy = (state==FILL); done = (state==DONE).
REQ-014 SHALL, on start in any state: state<=FILL, bit counter<=0, wr_ptr<=0, rd_ptr<=0, words<=0, rd_err<=0; din on the start cycle is not captured.
REQ-015 SHALL, in FILL, shift din into a 16-bit shift register each clk: shift left, new bit into bit 0, so the first sample of a word ends in bit 15.
REQ-016 SHALL, on the 16th bit of each word, write {shift[14:0],din} to mem[wr_ptr] on that same edge, then increment wr_ptr and words.
REQ-017 SHALL go FILL->DONE on the edge that writes word DEPTH-1; words then reads DEPTH; no further writes occur until the next start.
REQ-018 SHALL take exactly 16*DEPTH clk from the first captured sample to done=1 (16384 clk for the default).
REQ-019 SHALL, on rd in DONE: dout<=mem[rd_ptr] and rd_ptr<=rd_ptr+1 on the same edge; dout is valid on the cycle after rd; rd pulses may be back-to-back.
REQ-020 SHALL wrap rd_ptr from DEPTH-1 to 0, so a second read pass returns the same data; state stays DONE.
REQ-021 SHALL, on rd in IDLE or FILL: leave dout and rd_ptr unchanged and set rd_err.
REQ-022 SHALL, when start and rd occur in the same cycle, give start priority; that rd is ignored and rd_err is not set.
REQ-023 SHALL hold dout stable between rd pulses, including across start.
REQ-024 SHALL infer the buffer as synchronous block RAM: one write port (FILL), one read port (rd), with no read-during-write hazard, because writes and reads occur in disjoint states.

Reset
REQ-025 SHALL, on rst asserted: state=IDLE, dout=0, busy=0, done=0, words=0, rd_err=0, all pointers and the bit counter 0, shift register 0; memory contents are undefined.
REQ-026 SHALL, on rst asserted mid-FILL or mid-read, abort immediately; a new start is then required, and rd before that start sets rd_err.
REQ-027 SHALL ignore start and rd on the first edge after rst deasserts only if they are sampled while rst is still high.

Verification
REQ-028 SHALL be verified with: DEPTH=16, start, then din = repeating 1010... -> done after exactly 256 clk; 16 rd pulses -> dout = 0xAAAA each; busy=0.
REQ-029 SHALL be verified with: DEPTH=16, din = a 16-bit counter pattern, word k = k (MSB first) -> rd sequence returns 0x0000..0x000F; the 17th rd returns 0x0000 (wrap).
REQ-030 SHALL be verified with: rd issued in IDLE and mid-FILL -> rd_err=1, dout unchanged, rd_ptr unchanged; the next start clears rd_err.
REQ-031 SHALL be verified with: start re-issued at clk 100 of FILL -> words returns to 0, and done asserts 256 clk after the second start's capture begins.
REQ-032 SHALL be verified with: rst pulsed mid-FILL (words=5) -> all outputs 0 within the same cycle (asynchronous), state IDLE; a subsequent rd sets rd_err.
REQ-033 SHALL be verified with: start and rd in the same cycle while DONE -> a new FILL begins, rd_err=0, dout unchanged.

Source files
------------

// File: rtl/gps_sample_capture.sv
// Captures a 1-bit GPS sample stream into a DEPTH x 16-bit buffer, then replays it word by word on rd.
// Write on the 16th bit of each word; dout is registered, so a word is valid on the cycle after rd.
module gps_sample_capture #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          start,
    input  logic          rd,
    output logic [15:0]   dout,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   words,
    output logic          rd_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   WORD_ONE = (AW + 1)'(1);

    state_t          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [15:0]     shift_q, shift_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     words_q, words_d;
    logic            rd_err_q, rd_err_d;
    logic [15:0]     dout_q, dout_d;

    logic            wr_en;
    logic [15:0]     wr_dat;

    logic [15:0]     mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        words_d   = words_q;
        rd_err_d  = rd_err_q;
        dout_d    = dout_q;
        wr_en     = 1'b0;
        wr_dat    = {shift_q[14:0], din};

        if (start) begin
            // start wins over rd and drops the sample presented on its own cycle
            state_d   = FILL;
            bit_cnt_d = 4'd0;
            shift_d   = 16'd0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            words_d   = '0;
            rd_err_d  = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    shift_d   = {shift_q[14:0], din};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        words_d  = words_q + WORD_ONE;
                        if (wr_ptr_q == PTR_LAST) begin
                            state_d = DONE;
                        end
                    end
                end
                default: ;
            endcase

            if (rd) begin
                if (state_q == DONE) begin
                    // rd_ptr wraps naturally at DEPTH, giving repeat read passes
                    dout_d   = mem[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end else begin
                    rd_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 16'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            words_q   <= '0;
            rd_err_q  <= 1'b0;
            dout_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            words_q   <= words_d;
            rd_err_q  <= rd_err_d;
            dout_q    <= dout_d;
        end
    end

    // Buffer has no reset so it maps onto block RAM; writes only happen in FILL, reads only in DONE
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_dat;
        end
    end

    assign dout   = dout_q;
    assign busy   = (state_q == FILL);
    assign done   = (state_q == DONE);
    assign words  = words_q;
    assign rd_err = rd_err_q;

endmodule
